// File: rtl/sdp_y_core_alu_out_rr_arb_if.sv
// Beat handshake bundle for the SDP Y-core ALU output arbiter.
// Three requester lanes in, one registered chn_alu_out lane out.
interface sdp_y_core_alu_out_rr_arb_if;
  logic [2:0]  in_vld;
  logic [2:0]  in_rdy;
  logic [95:0] in_pd;
  logic [2:0]  in_last;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_pd;
  logic        out_last;
  logic [1:0]  out_src;

  modport master (
    output in_vld, in_pd, in_last, out_rdy,
    input  in_rdy, out_vld, out_pd, out_last, out_src
  );

  modport slave (
    input  in_vld, in_pd, in_last, out_rdy,
    output in_rdy, out_vld, out_pd, out_last, out_src
  );
endinterface

// File: rtl/sdp_y_core_alu_out_rr_arb.sv
// Burst-locked round-robin arbiter, 3 requesters onto chn_alu_out.
// Optional stall counter: define SDP_ALU_OUT_ARB_PERF_EN.
module sdp_y_core_alu_out_rr_arb (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  sdp_y_core_alu_out_rr_arb_if.slave    bus,
  input  logic                          perf_clr,
  output logic [15:0]                   perf_stall_cnt
);

  localparam logic [0:0] ST_OPEN = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]  state;
  logic [1:0]  lock_src;
  logic [1:0]  ptr;
  logic [2:0]  gnt;
  logic        pipe_rdy;
  logic        xfer;
  logic [1:0]  sel_src;
  logic [31:0] sel_pd;
  logic        sel_last;

  assign pipe_rdy = !bus.out_vld | bus.out_rdy;
  assign bus.in_rdy = gnt & {3{pipe_rdy & nvdla_core_rstn}};
  assign xfer = |(bus.in_vld & bus.in_rdy);

  // Grant: stick to the burst owner, else rotate from ptr+1.
  always_comb begin
    gnt = 3'b000;
    if (state == ST_LOCK) begin
      unique case (lock_src)
        2'd0:    gnt[0] = bus.in_vld[0];
        2'd1:    gnt[1] = bus.in_vld[1];
        default: gnt[2] = bus.in_vld[2];
      endcase
    end else begin
      unique case (ptr)
        2'd0:
          gnt = bus.in_vld[1] ? 3'b010 :
                bus.in_vld[2] ? 3'b100 :
                bus.in_vld[0] ? 3'b001 : 3'b000;
        2'd1:
          gnt = bus.in_vld[2] ? 3'b100 :
                bus.in_vld[0] ? 3'b001 :
                bus.in_vld[1] ? 3'b010 : 3'b000;
        default:
          gnt = bus.in_vld[0] ? 3'b001 :
                bus.in_vld[1] ? 3'b010 :
                bus.in_vld[2] ? 3'b100 : 3'b000;
      endcase
    end
  end

  // Steer the granted lane's beat toward the output register.
  always_comb begin
    sel_src  = 2'd0;
    sel_pd   = bus.in_pd[31:0];
    sel_last = bus.in_last[0];
    unique case (1'b1)
      gnt[1]: begin
        sel_src  = 2'd1;
        sel_pd   = bus.in_pd[63:32];
        sel_last = bus.in_last[1];
      end
      gnt[2]: begin
        sel_src  = 2'd2;
        sel_pd   = bus.in_pd[95:64];
        sel_last = bus.in_last[2];
      end
      default: begin
        sel_src  = 2'd0;
        sel_pd   = bus.in_pd[31:0];
        sel_last = bus.in_last[0];
      end
    endcase
  end

  // Burst lock and round-robin pointer, updated on accepted beats.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state    <= ST_OPEN;
      lock_src <= 2'd0;
      ptr      <= 2'd2;
    end else if (xfer) begin
      if (sel_last) begin
        state <= ST_OPEN;
        ptr   <= sel_src;
      end else begin
        state    <= ST_LOCK;
        lock_src <= sel_src;
      end
    end
  end

  // Single output register; reload on drain keeps 1 beat/cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      bus.out_vld  <= 1'b0;
      bus.out_pd   <= 32'h0;
      bus.out_last <= 1'b0;
      bus.out_src  <= 2'd0;
    end else if (xfer) begin
      bus.out_vld  <= 1'b1;
      bus.out_pd   <= sel_pd;
      bus.out_last <= sel_last;
      bus.out_src  <= sel_src;
    end else if (bus.out_rdy) begin
      bus.out_vld  <= 1'b0;
    end
  end

`ifdef SDP_ALU_OUT_ARB_PERF_EN
  // Saturating count of cycles the output beat is back-pressured.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_stall_cnt <= 16'h0;
    end else if (perf_clr) begin
      perf_stall_cnt <= 16'h0;
    end else if (bus.out_vld && !bus.out_rdy &&
                 perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'h1;
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_sdp_y_core_alu_out_rr_arb.sv
// Directed bench with output scoreboard for the ALU-out arbiter.
// Stall-counter expectations follow SDP_ALU_OUT_ARB_PERF_EN.
module tb_sdp_y_core_alu_out_rr_arb;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] pd;
    logic        last;
  } beat_t;

`ifdef SDP_ALU_OUT_ARB_PERF_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        perf_clr = 1'b0;
  logic [15:0] perf_cnt;

  int    comps = 0;
  int    errs = 0;
  int    pops = 0;
  beat_t sb[$];

  sdp_y_core_alu_out_rr_arb_if bus ();

  sdp_y_core_alu_out_rr_arb dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .bus             (bus.slave),
    .perf_clr        (perf_clr),
    .perf_stall_cnt  (perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    comps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pdv(input int s, input int k);
    return 32'hA000_0000 | (32'(s) << 16) | 32'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input int k);
    for (int i = 0; i < 3; i++)
      bus.in_pd[32*i +: 32] = pdv(i, k);
  endtask

  task automatic push(input int s, input logic [31:0] pd,
                      input logic last);
    beat_t b;
    b.src  = 2'(s);
    b.pd   = pd;
    b.last = last;
    sb.push_back(b);
  endtask

  // Scoreboard: every drained output beat must match the oldest push.
  always @(negedge clk) begin
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      beat_t got;
      beat_t exp;
      got.src  = bus.out_src;
      got.pd   = bus.out_pd;
      got.last = bus.out_last;
      comps++;
      pops++;
      assert (sb.size() != 0) else begin
        errs++;
        $error("FAIL sb_extra: observed %0h expected none", got);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        comps++;
        assert (got === exp) else begin
          errs++;
          $error("FAIL sb_beat: observed %0h expected %0h", got, exp);
        end
      end
    end
  end

  initial begin
    int e;
    int sent;
    int cyc;
    int pop0;
    logic lst;
    int exp1 [4] = '{0, 1, 2, 0};

    bus.in_vld  = 3'b111;
    bus.in_last = 3'b000;
    bus.in_pd   = '0;
    bus.out_rdy = 1'b0;

    // reset state
    #2;
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_pd", bus.out_pd, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_perf", perf_cnt, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_rdy = 1'b1;

    // round robin, all last
    bus.in_last = 3'b111;
    bus.in_vld  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      e = exp1[k];
      set_pd(k);
      #1;
      if (k == 0) chk("rr_lat_pre", bus.out_vld, 0);
      chk("rr_in_rdy", bus.in_rdy, 64'(1) << e);
      push(e, pdv(e, k), 1'b1);
      step();
      chk("rr_out_vld", bus.out_vld, 1);
      chk("rr_out_src", bus.out_src, e);
    end
    bus.in_vld = 3'b000;
    step();

    // req1 locked burst of 4, then req2
    bus.in_vld = 3'b111;
    for (int k = 0; k < 5; k++) begin
      e = (k < 4) ? 1 : 2;
      bus.in_last = (k == 3) ? 3'b111 : 3'b101;
      lst = (e == 2) || (k == 3);
      set_pd(10 + k);
      #1;
      chk("burst_in_rdy", bus.in_rdy, 64'(1) << e);
      push(e, pdv(e, 10 + k), lst);
      step();
      chk("burst_out_src", bus.out_src, e);
    end
    bus.in_vld = 3'b000;
    step();

    // stall with held beat
    bus.in_vld = 3'b001;
    bus.in_last = 3'b111;
    bus.in_pd[31:0] = 32'hDEADBEEF;
    bus.out_rdy = 1'b0;
    #1;
    chk("stall_first_rdy", bus.in_rdy, 3'b001);
    push(0, 32'hDEADBEEF, 1'b1);
    step();
    bus.in_vld = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_in_rdy", bus.in_rdy, 0);
      chk("stall_out_pd", bus.out_pd, 32'hDEADBEEF);
      chk("stall_out_vld", bus.out_vld, 1);
      step();
    end
    chk("stall_out_pd_end", bus.out_pd, 32'hDEADBEEF);
    chk("stall_cnt5", perf_cnt, PE ? 5 : 0);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("stall_clr", perf_cnt, 0);
`ifdef SDP_ALU_OUT_ARB_PERF_EN
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", perf_cnt, 16'hFFFF);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("stall_sat_clr", perf_cnt, 0);
`endif
    bus.in_vld = 3'b000;
    bus.out_rdy = 1'b1;
    step();

    // locked req0 burst, requester drop, reset mid-burst
    bus.in_vld = 3'b001;
    bus.in_last = 3'b000;
    set_pd(20);
    #1;
    chk("lock_b1_rdy", bus.in_rdy, 3'b001);
    push(0, pdv(0, 20), 1'b0);
    step();
    bus.in_vld = 3'b110;
    bus.in_last = 3'b111;
    #1;
    chk("lock_drop_rdy", bus.in_rdy, 0);
    step();
    bus.in_vld = 3'b111;
    bus.in_last = 3'b000;
    set_pd(21);
    #1;
    chk("lock_b2_rdy", bus.in_rdy, 3'b001);
    step();
    chk("lock_b2_vld", bus.out_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", bus.out_vld, 0);
    chk("midrst_in_rdy", bus.in_rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_vld = 3'b110;
    bus.in_last = 3'b111;
    set_pd(22);
    #1;
    chk("postrst_in_rdy", bus.in_rdy, 3'b010);
    push(1, pdv(1, 22), 1'b1);
    step();
    chk("postrst_out_src", bus.out_src, 1);
    bus.in_vld = 3'b000;
    step();

    // 100 beats from req2 under toggling back-pressure
    pop0 = pops;
    sent = 0;
    cyc = 0;
    bus.in_vld = 3'b100;
    bus.in_last = 3'b111;
    while (sent < 100 && cyc < 1000) begin
      bus.out_rdy = cyc[0];
      bus.in_pd[95:64] = 32'hB000_0000 + 32'(sent);
      #1;
      if (bus.in_rdy[2]) begin
        push(2, 32'hB000_0000 + 32'(sent), 1'b1);
        sent++;
      end
      step();
      cyc++;
    end
    chk("tog_sent", sent, 100);
    bus.in_vld = 3'b000;
    bus.out_rdy = 1'b1;
    repeat (3) step();
    chk("tog_drained", pops - pop0, 100);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             comps, errs);
    $finish;
  end

endmodule

// File: doc/sdp_y_core_alu_out_rr_arb.md
SDP_Y_CORE_ALU_OUT_RR_ARB -- requirements
Module: sdp_y_core_alu_out_rr_arb

Interface
REQ-001 SHALL use clock nvdla_core_clk (input, 1): all state on rising edge.
REQ-002 SHALL use reset nvdla_core_rstn (input, 1): asynchronous, active-low.
REQ-003 SHALL have in_vld (input, 3): per-requester beat valid; index 0..2.
REQ-004 SHALL have in_rdy (output, 3): per-requester beat accept.
REQ-005 SHALL have in_pd (input, 96): requester i payload at bits [32i+31:32i].
REQ-006 SHALL have in_last (input, 3): requester i beat closes its burst.
REQ-007 SHALL have out_vld (output, 1): registered output beat valid.
REQ-008 SHALL have out_rdy (input, 1): downstream chn_alu_out accept.
REQ-009 SHALL have out_pd (output, 32): registered payload.
REQ-010 SHALL have out_last (output, 1): registered last flag.
REQ-011 SHALL have out_src (output, 2): registered source index (0..2) of out_pd.
REQ-012 SHALL have perf_clr (input, 1): synchronous stall-counter clear.
REQ-013 SHALL have perf_stall_cnt (output, 16): output-stall cycle count.

Function
REQ-014 SHALL define pipe_rdy = !out_vld | out_rdy; a transfer on requester i is in_vld[i] & in_rdy[i].
REQ-015 SHALL assert at most one in_rdy bit per cycle, only while pipe_rdy=1 and that requester is granted.
REQ-016 SHALL, when unlocked, grant the first requester with in_vld=1 searching cyclically from (ptr+1) mod 3; none valid -> in_rdy=0.
REQ-017 SHALL, when locked, grant only lock_src, regardless of other in_vld.
REQ-018 SHALL enter lock (lock_src=i) on a transfer with in_last[i]=0, and leave lock on a transfer with in_last[i]=1.
REQ-019 SHALL set ptr=i on every transfer with in_last[i]=1; ptr is otherwise unchanged.
REQ-020 SHALL load out_pd/out_last/out_src and set out_vld=1 on the edge after a transfer (latency 1 cycle).
REQ-021 SHALL clear out_vld when out_rdy=1 and no transfer occurs that cycle; a simultaneous drain and transfer keeps out_vld=1 with new data (full throughput, 1 beat/cycle).
REQ-022 SHALL hold out_pd/out_last/out_src stable while out_vld=1 & out_rdy=0.
REQ-023 SHALL not depend combinationally from out_rdy to out_vld/out_pd; in_rdy may depend combinationally on out_rdy and in_vld.
REQ-024 SHALL tolerate in_vld dropping while locked: lock persists, no beats forwarded, no grant moves.
REQ-025 SHALL treat 3-requester wrap-around: ptr=2 -> search order 0,1,2.

Reset
REQ-026 SHALL on nvdla_core_rstn=0 force out_vld=0, out_pd=0, out_last=0, out_src=0, lock=0, lock_src=0, ptr=2, perf_stall_cnt=0.
REQ-027 SHALL, on reset mid-burst, discard the lock and held beat; first post-reset grant follows REQ-016 with ptr=2.
REQ-028 SHALL drive in_rdy=0 while reset is asserted.

Configuration
REQ-029 SHALL compile the stall counter only when macro SDP_ALU_OUT_ARB_PERF_EN is defined.
REQ-030 SHALL, with SDP_ALU_OUT_ARB_PERF_EN, increment perf_stall_cnt each cycle out_vld=1 & out_rdy=0, saturating at 16'hFFFF; perf_clr=1 clears to 0 with priority over increment.
REQ-031 SHALL, without SDP_ALU_OUT_ARB_PERF_EN, tie perf_stall_cnt to 16'h0000, ignore perf_clr, keep ports and all other behaviour identical.

Verification
REQ-032 SHALL test: after reset, in_vld=3'b111 all last=1, out_rdy=1 -> out_src sequence 0,1,2,0 on consecutive cycles, out_vld first high 1 cycle after first transfer.
REQ-033 SHALL test: req1 burst of 4 beats (last on 4th) with req0/req2 valid throughout -> 4 consecutive out_src=1 beats, then out_src=2.
REQ-034 SHALL test: out_vld=1, out_rdy=0 for 5 cycles, pd=32'hDEADBEEF -> out_pd stable, in_rdy=3'b000, perf_stall_cnt=5 (PERF_EN) or 0 (no PERF_EN).
REQ-035 SHALL test: stall held 70000 cycles -> perf_stall_cnt saturates at 16'hFFFF; perf_clr pulse -> 0 next cycle.
REQ-036 SHALL test: reset asserted after 2nd beat of a locked req0 burst -> out_vld=0 immediately; after release with in_vld=3'b110, first grant is req1.
REQ-037 SHALL test: single requester 2 valid, out_rdy toggling 1/0 each cycle -> no beat lost or duplicated over 100 beats (scoreboard match).
